// File: rtl/poly_basemul_seq.sv
// poly_basemul_seq: streams N_PAIRS operand pairs from the A/B memories into
// base_case_mul, one pair per cycle, and retires each product pair to the
// result memory at the address it was issued with.
module poly_basemul_seq #(
  parameter  int N_PAIRS     = 128,
  parameter  int MUL_LATENCY = 2,
  localparam int AW          = $clog2(N_PAIRS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [11:0]   a0_i,
  input  logic [11:0]   a1_i,
  input  logic [11:0]   b0_i,
  input  logic [11:0]   b1_i,
  output logic          mul_valid_o,
  output logic [11:0]   mul_a0_o,
  output logic [11:0]   mul_a1_o,
  output logic [11:0]   mul_b0_o,
  output logic [11:0]   mul_b1_o,
  output logic [11:0]   mul_zeta_o,
  input  logic          mul_valid_i,
  input  logic [11:0]   mul_c0_i,
  input  logic [11:0]   mul_c1_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [11:0]   wr_c0_o,
  output logic [11:0]   wr_c1_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  // zeta[i] = 17^(2*brv(i)+1) mod 3329, evaluated at elaboration time
  function automatic int zeta_f(input int idx);
    int rev, e, z;
    rev = 0;
    for (int b = 0; b < AW; b++)
      if (((idx >> b) & 1) != 0) rev = rev | (1 << (AW - 1 - b));
    e = 2 * rev + 1;
    z = 1;
    for (int j = 0; j < e; j++) z = (z * 17) % 3329;
    return z;
  endfunction

  logic [11:0] zeta_rom [N_PAIRS];
  for (genvar g = 0; g < N_PAIRS; g++) begin : g_zeta
    localparam logic [11:0] Z = 12'(zeta_f(g));
    assign zeta_rom[g] = Z;
  end

  state_e                         state_q, state_d;
  logic [AW-1:0]                  iss_cnt_q, iss_cnt_d;
  logic [AW:0]                    wr_cnt_q, wr_cnt_d;
  logic                           err_q, err_d;
  logic                           tag_vld_q, tag_vld_d;
  logic [AW-1:0]                  tag_addr_q, tag_addr_d;
  logic [11:0]                    zeta_q, zeta_d;
  logic [MUL_LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
  logic [MUL_LATENCY-1:0][AW-1:0] tag_pipe_q, tag_pipe_d;
  logic                           active, rd_en, pipe_vld;

  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign rd_en    = (state_q == S_RUN);
  assign pipe_vld = vld_pipe_q[MUL_LATENCY-1];

  // Sequencer: next state, issue/write counters and sticky protocol error
  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    // multiplier result without a matching tag, or a tag whose result never
    // came; the write counter follows the tag so a lost result cannot hang us
    if (active && (mul_valid_i != pipe_vld)) err_d = 1'b1;
    if (active && pipe_vld) wr_cnt_d = wr_cnt_q + (AW+1)'(1);
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_RUN;
        iss_cnt_d = '0;
        wr_cnt_d  = '0;
        err_d     = 1'b0;
      end
      S_RUN: begin
        iss_cnt_d = iss_cnt_q + AW'(1);
        if (iss_cnt_q == AW'(N_PAIRS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (wr_cnt_d == (AW+1)'(N_PAIRS)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue tag/zeta register and the tag delay line matching the multiplier
  always_comb begin
    tag_vld_d     = rd_en;
    tag_addr_d    = rd_en ? iss_cnt_q : '0;
    zeta_d        = rd_en ? zeta_rom[iss_cnt_q] : '0;
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = tag_vld_q;
    tag_pipe_d[0] = tag_addr_q;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  // State registers; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iss_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
      zeta_q     <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      tag_vld_q  <= tag_vld_d;
      tag_addr_q <= tag_addr_d;
      zeta_q     <= zeta_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign busy_o      = active;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = rd_en ? iss_cnt_q : '0;
  // operand data is only meaningful alongside its valid; hold zero otherwise
  assign mul_valid_o = tag_vld_q;
  assign mul_a0_o    = tag_vld_q ? a0_i : '0;
  assign mul_a1_o    = tag_vld_q ? a1_i : '0;
  assign mul_b0_o    = tag_vld_q ? b0_i : '0;
  assign mul_b1_o    = tag_vld_q ? b1_i : '0;
  assign mul_zeta_o  = zeta_q;
  assign wr_en_o     = active && mul_valid_i && pipe_vld;
  assign wr_addr_o   = wr_en_o ? tag_pipe_q[MUL_LATENCY-1] : '0;
  assign wr_c0_o     = wr_en_o ? mul_c0_i : '0;
  assign wr_c1_o     = wr_en_o ? mul_c1_i : '0;

endmodule

// File: doc/poly_basemul_seq.md
# poly_basemul_seq

Sequencer that performs one full NTT-domain polynomial multiply (FIPS 203 MultiplyNTTs) by streaming 128 coefficient pairs from the A and B operand memories into the 2-cycle `base_case_mul` datapath and writing each product pair back to the result memory. It sits directly upstream and downstream of `base_case_mul` in the poly-arith unit:

- generates read addresses and the per-pair zeta;
- tags each issued pair with its destination address;
- retires the multiplier's results to the write port.

## Interface
Parameters:
- `N_PAIRS`, default 128: coefficient pairs per polynomial. Address width is `$clog2(N_PAIRS)` = 7.
- `MUL_LATENCY`, default 2: fixed cycles from multiplier `valid_i` to `valid_o`.

Ports (`coeff_t` is the 12-bit coefficient type from `poly_arith_pkg`):
- `clk` in 1: clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a multiply. Sampled only in IDLE.
- `busy_o` out 1: high from the cycle after start until the last write.
- `done_o` out 1: single-cycle pulse after the final write.
- `err_o` out 1: sticky protocol error. Cleared by accepted start or by reset.
- `rd_en_o` out 1: operand memory read strobe.
- `rd_addr_o` out 7: pair index to read from A and B.
- `a0_i`, `a1_i`, `b0_i`, `b1_i` in `coeff_t`: operand read data, valid exactly 1 cycle after `rd_en_o` (synchronous RAM).
- `mul_valid_o` out 1: drives multiplier `valid_i`.
- `mul_a0_o`, `mul_a1_o`, `mul_b0_o`, `mul_b1_o`, `mul_zeta_o` out `coeff_t`: multiplier operands.
- `mul_valid_i` in 1: multiplier `valid_o`.
- `mul_c0_i`, `mul_c1_i` in `coeff_t`: multiplier results.
- `wr_en_o` out 1: result write strobe.
- `wr_addr_o` out 7: destination pair index.
- `wr_c0_o`, `wr_c1_o` out `coeff_t`: result data.

## Operation
FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE:** `start_i`=1 moves to RUN. The issue counter and write counter clear, and `err_o` clears.
- **RUN:** `rd_en_o`=1 and `rd_addr_o` = issue counter, which increments each cycle. After issuing index `N_PAIRS`-1, the FSM moves to DRAIN.
- **DRAIN:** no reads. When the write counter reaches `N_PAIRS`, the FSM moves to DONE.
- **DONE:** `done_o`=1 for one cycle, then IDLE.

Issue pipeline:
- `rd_en_o` and `rd_addr_o` are registered into a 1-stage tag register.
- The next cycle, `mul_valid_o` equals the delayed `rd_en_o`.
- `mul_a*`/`mul_b*` pass read data straight through.
- `mul_zeta_o` is the registered lookup of an internal 128-entry constant ROM at the delayed address: zeta[i] = 17^(2·brv7(i)+1) mod 3329. Examples: zeta[0]=17, zeta[1]=3312, zeta[2]=2761, zeta[3]=568.
- `mul_zeta_o` is 0 whenever `mul_valid_o`=0.

Write-back:
- The tag (address) travels through a `MUL_LATENCY`-deep shift register alongside `mul_valid_o`.
- `wr_en_o` = `mul_valid_i` AND state in {RUN, DRAIN}.
- `wr_addr_o` is the tag at the end of the delay line.
- `wr_c0_o`/`wr_c1_o` pass `mul_c0_i`/`mul_c1_i` through unchanged. No arithmetic is done in this block; the multiplier output is already reduced to [0, 3328].

Boundary rules:
- `start_i` outside IDLE is ignored.
- `mul_valid_i`=1 when the delay-line valid bit at the same position is 0 sets `err_o`; no write is produced.
- The delay-line valid bit set without `mul_valid_i` also sets `err_o`; the write counter still advances so the run terminates.
- `mul_valid_i` in IDLE or DONE is ignored.
- Reset mid-operation: returns to IDLE and clears all counters, tags and outputs. No writes are issued after reset; the multiplier shares `rst`.

## Timing
- Reset values: all outputs 0. State IDLE.
- `start_i` sampled high at edge k:
  - `busy_o`=1 from cycle k+1.
  - `rd_en_o`=1 on cycles k+1 … k+128, with addresses 0…127.
  - `mul_valid_o`=1 on k+2 … k+129.
  - `wr_en_o`=1 on k+4 … k+131, with addresses 0…127 in order.
  - `done_o`=1 at k+132; `busy_o` is 0 at k+132.
  - The next `start_i` is accepted at edge k+133 at the earliest.
- Throughput: one pair per cycle. No bubbles and no backpressure.

## Test plan
- **Reset:** assert `rst` for 5 cycles → all outputs 0 and `busy_o`=0. Assert `start_i` during reset → no reads.
- **Identity run:** A = (1,0) for every pair, B = random → 128 writes with `wr_addr_o` 0…127 on cycles k+4…k+131 and `wr_c0_o`/`wr_c1_o` = B pair. `done_o` pulses once at k+132.
- **Zeta ROM:** A = B = (0,1) for every pair → `wr_c0_o` = zeta[i], i.e. 17, 3312, 2761, 568 for pairs 0–3, all 128 entries checked against the formula; `wr_c1_o`=0.
- **Start while busy:** pulse `start_i` at k+10 and k+130 → exactly one `done_o` and 128 writes.
- **Reset mid-run:** assert `rst` at k+50 → no `wr_en_o` afterwards, all outputs 0. A restart completes with correct data and golden-model results for random A and B.
- **Protocol error:** inject an extra `mul_valid_i` pulse at k+3 (monitor adds one cycle) → `err_o`=1 and stays high until the next start. No spurious write; `done_o` still pulses.
